instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 230 +++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage sitting directly in front of instr_decoder. Owns the PC,
//   issues word reads to instruction memory, buffers the in-order responses
//   together with the address each one was fetched from, and hands
//   {instr, instr_pc} to the decoder. A redirect from branch resolution
//   reloads the PC, flushes everything buffered and arranges for the
//   responses still in flight to be thrown away when they arrive.
//
// Parameters
//   RESET_PC    PC loaded on reset (word aligned)
//   FIFO_DEPTH  instruction buffer entries, also the request credit (2..8)
//
// Optional feature
//   INSTR_FETCH_ILLEGAL_CHECK_EN  adds output instr_illegal, a per-entry flag
//                                 computed when the response is buffered.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mem_req_valid/ready/addr  word read request channel to instruction memory
//   mem_rsp_valid/data        in-order read responses, no backpressure
//   redirect_valid/pc         PC redirect (low two bits are ignored)
//   instr_valid/ready         handshake towards the decoder
//   instr, instr_pc           buffered instruction word and its address
//   instr_illegal             (optional) head entry failed the opcode check
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  output logic        instr_illegal,
`endif
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW:0]   CREDIT   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  // Circular pointer advance; FIFO_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PW'(1'b1);
    end
    return nxt;
  endfunction

`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  // Only 32-bit encodings of LOAD, STORE, BRANCH, OP_IMM, OP and LUI pass.
  function automatic logic illegal_word(input logic [31:0] word);
    logic bad;
    case (word[6:2])
      5'b00000, 5'b01000, 5'b11000,
      5'b00100, 5'b01100, 5'b01101: bad = 1'b0;
      default:                      bad = 1'b1;
    endcase
    if (word[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction
`endif

  logic [31:0]   pc_r;
  logic [CW-1:0] out_cnt_r;    // requests accepted, response not yet seen
  logic [CW-1:0] drop_cnt_r;   // responses still owed from before a redirect
  logic [CW-1:0] fifo_cnt_r;
  logic [PW-1:0] fifo_rd_r;
  logic [PW-1:0] fifo_wr_r;
  logic [PW-1:0] tag_rd_r;
  logic [PW-1:0] tag_wr_r;
  logic [31:0]   fifo_data_r [FIFO_DEPTH];
  logic [31:0]   fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]   tag_q_r     [FIFO_DEPTH];
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  logic          fifo_ill_r  [FIFO_DEPTH];
`endif

  logic [CW:0]   credit_sum_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          keep_rsp_s;
  logic          pop_s;
  logic [CW-1:0] rsp_dec_s;

  // Every buffered entry or in-flight request holds one credit, so the
  // buffer can always absorb every response that is still owed.
  assign credit_sum_s = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_r};
  assign req_valid_s  = !rst && !redirect_valid && (credit_sum_s < CREDIT);
  assign req_fire_s   = req_valid_s && mem_req_ready;
  // A response landing in a redirect cycle is stale by definition.
  assign keep_rsp_s   = mem_rsp_valid && (drop_cnt_r == CNT_ZERO) && !redirect_valid;
  assign pop_s        = (fifo_cnt_r != CNT_ZERO) && instr_ready;
  assign rsp_dec_s    = CW'(mem_rsp_valid);

  assign mem_req_valid = req_valid_s;
  assign mem_req_addr  = pc_r;
  assign instr_valid   = (fifo_cnt_r != CNT_ZERO);
  assign instr         = fifo_data_r[fifo_rd_r];
  assign instr_pc      = fifo_pc_r[fifo_rd_r];
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  assign instr_illegal = fifo_ill_r[fifo_rd_r];
`endif

  // PC, credit counters, tag queue and instruction buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      out_cnt_r  <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
      fifo_cnt_r <= CNT_ZERO;
      fifo_rd_r  <= PTR_ZERO;
      fifo_wr_r  <= PTR_ZERO;
      tag_rd_r   <= PTR_ZERO;
      tag_wr_r   <= PTR_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]   <= 32'h0000_0000;
        tag_q_r[i]     <= 32'h0000_0000;
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
        fifo_ill_r[i]  <= 1'b0;
`endif
      end
    end else if (redirect_valid) begin
      // Masking keeps every redirect_pc bit in use while forcing alignment.
      pc_r       <= redirect_pc & 32'hFFFF_FFFC;
      out_cnt_r  <= out_cnt_r - rsp_dec_s;
      // Everything still in flight belongs to the old stream.
      drop_cnt_r <= out_cnt_r - rsp_dec_s;
      fifo_cnt_r <= CNT_ZERO;
      fifo_rd_r  <= PTR_ZERO;
      fifo_wr_r  <= PTR_ZERO;
      tag_rd_r   <= PTR_ZERO;
      tag_wr_r   <= PTR_ZERO;
    end else begin
      out_cnt_r  <= out_cnt_r + CW'(req_fire_s) - rsp_dec_s;
      fifo_cnt_r <= fifo_cnt_r + CW'(keep_rsp_s) - CW'(pop_s);

      if (req_fire_s) begin
        pc_r              <= pc_r + 32'd4;
        tag_q_r[tag_wr_r] <= pc_r;
        tag_wr_r          <= ptr_inc(tag_wr_r);
      end

      // Dropped responses never had a tag pushed after the flush, so the
      // tag queue only advances on responses that are kept.
      if (mem_rsp_valid && (drop_cnt_r != CNT_ZERO)) begin
        drop_cnt_r <= drop_cnt_r - CW'(1'b1);
      end

      if (keep_rsp_s) begin
        fifo_data_r[fifo_wr_r] <= mem_rsp_data;
        fifo_pc_r[fifo_wr_r]   <= tag_q_r[tag_rd_r];
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
        fifo_ill_r[fifo_wr_r]  <= illegal_word(mem_rsp_data);
`endif
        fifo_wr_r <= ptr_inc(fifo_wr_r);
        tag_rd_r  <= ptr_inc(tag_rd_r);
      end

      if (pop_s) begin
        fifo_rd_r <= ptr_inc(fifo_rd_r);
      end
    end
  end

  instr_fetch_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .mem_rsp_valid (mem_rsp_valid),
    .out_cnt       (out_cnt_r),
    .fifo_cnt      (fifo_cnt_r)
  );

endmodule

// ---------------------------------------------------------------------------
// instr_fetch_chk
//   Protocol and credit invariants for instr_fetch.
//   Ports: clk, rst, mem_rsp_valid, out_cnt (requests in flight),
//          fifo_cnt (buffered entries).
// ---------------------------------------------------------------------------
module instr_fetch_chk #(
  parameter int FIFO_DEPTH = 2,
  parameter int CW         = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          mem_rsp_valid,
  input logic [CW-1:0] out_cnt,
  input logic [CW-1:0] fifo_cnt
);

  // A response with nothing in flight means memory broke the protocol.
  a_rsp_has_request: assert property (
    @(posedge clk) disable iff (rst) mem_rsp_valid |-> (out_cnt != {CW{1'b0}})
  );

  // Credits held by in-flight requests and buffered entries never exceed depth.
  a_credit_bound: assert property (
    @(posedge clk) disable iff (rst)
      ({1'b0, out_cnt} + {1'b0, fifo_cnt}) <= (CW + 1)'(FIFO_DEPTH)
  );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
  logic        instr_illegal;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
    .instr_illegal  (instr_illegal),
`endif
    .instr_pc       (instr_pc)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;
  int cyc       = 0;
  int mem_lat   = 1;
  int first_valid_cyc;
  logic        last_req_valid;
  logic        data_ovr_en = 1'b0;
  logic [31:0] data_ovr    = 32'h0000_0000;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] req_log   [$];
  logic [31:0] pc_log    [$];
  logic [31:0] dat_log   [$];
  logic [31:0] ill_log   [$];

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: memory model drives the response due now, requests and
  // consumed instructions are logged, then the clock edge is taken.
  task automatic run_cycle();
    if (pend_addr.size() != 0 && pend_due[0] == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data_ovr_en ? data_ovr : ~pend_addr[0];
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0000_0000;
    end
    #1;
    last_req_valid = mem_req_valid;
    if (mem_req_valid && mem_req_ready) begin
      req_log.push_back(mem_req_addr);
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(cyc + mem_lat);
    end
    if (instr_valid && instr_ready) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      pc_log.push_back(instr_pc);
      dat_log.push_back(instr);
`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
      ill_log.push_back({31'd0, instr_illegal});
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset(input int lat);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    instr_ready    = 1'b1;
    mem_lat        = lat;
    pend_addr.delete();
    pend_due.delete();
    run_n(2);
    check_eq("rst_req_valid",   {31'd0, mem_req_valid}, 32'd0);
    check_eq("rst_instr_valid", {31'd0, instr_valid},   32'd0);
    check_eq("rst_instr",       instr,                  32'h0000_0000);
    check_eq("rst_instr_pc",    instr_pc,               32'h0000_0000);
    rst = 1'b0;
    cyc = 0;
    first_valid_cyc = -1;
    req_log.delete();
    pc_log.delete();
    dat_log.delete();
    ill_log.delete();
  endtask

  initial begin
    rst            = 1'b1;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0000_0000;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    instr_ready    = 1'b1;

    // Straight-line fetch from RESET_PC, 1-cycle memory.
    do_reset(1);
    check_eq("first_req_addr", mem_req_addr, 32'h0000_0100);
    run_n(12);
    check_eq("seq_req0", q_at(req_log, 0), 32'h0000_0100);
    check_eq("seq_req1", q_at(req_log, 1), 32'h0000_0104);
    check_eq("seq_req2", q_at(req_log, 2), 32'h0000_0108);
    check_eq("seq_req3", q_at(req_log, 3), 32'h0000_010C);
    check_eq("fill_latency", first_valid_cyc, 32'd2);
    check_eq("seq_count_ge6", {31'd0, pc_log.size() >= 6}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("seq_pc%0d", i), q_at(pc_log, i), 32'h0000_0100 + 32'(4 * i));
    end
    check_eq("seq_dat0", q_at(dat_log, 0), 32'hFFFF_FEFF);
    check_eq("seq_dat3", q_at(dat_log, 3), 32'hFFFF_FEF3);

    // Stalled decoder: credit limits requests to the buffer depth.
    do_reset(1);
    instr_ready = 1'b0;
    run_n(10);
    check_eq("stall_req_count", req_log.size(), 32'd2);
    check_eq("stall_req_valid", {31'd0, last_req_valid}, 32'd0);
    check_eq("stall_head_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("stall_head_pc", instr_pc, 32'h0000_0100);
    instr_ready = 1'b1;
    run_n(8);
    check_eq("drain_pc0", q_at(pc_log, 0), 32'h0000_0100);
    check_eq("drain_pc1", q_at(pc_log, 1), 32'h0000_0104);
    check_eq("drain_pc2", q_at(pc_log, 2), 32'h0000_0108);
    check_eq("drain_pc3", q_at(pc_log, 3), 32'h0000_010C);

    // 3-cycle memory, two in flight, redirect to an unaligned target.
    do_reset(3);
    run_n(2);
    check_eq("lat3_inflight", req_log.size(), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2003;
    run_cycle();
    check_eq("redir_no_req", {31'd0, last_req_valid}, 32'd0);
    redirect_valid = 1'b0;
    run_n(14);
    check_eq("redir_req0", q_at(req_log, 2), 32'h0000_2000);
    check_eq("redir_req1", q_at(req_log, 3), 32'h0000_2004);
    check_eq("redir_pc0", q_at(pc_log, 0), 32'h0000_2000);
    check_eq("redir_pc1", q_at(pc_log, 1), 32'h0000_2004);
    check_eq("redir_dat0", q_at(dat_log, 0), 32'hFFFF_DFFF);

    // Redirect coinciding with a response, then a second redirect.
    do_reset(2);
    run_n(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    run_cycle();
    redirect_pc    = 32'h0000_4000;
    run_cycle();
    redirect_valid = 1'b0;
    check_eq("dbl_redir_empty", {31'd0, instr_valid}, 32'd0);
    run_n(10);
    check_eq("dbl_req_count_before", q_at(req_log, 1), 32'h0000_0104);
    check_eq("dbl_req_first", q_at(req_log, 2), 32'h0000_4000);
    check_eq("dbl_pc0", q_at(pc_log, 0), 32'h0000_4000);
    check_eq("dbl_pc1", q_at(pc_log, 1), 32'h0000_4004);
    check_eq("dbl_dat0", q_at(dat_log, 0), 32'hFFFF_BFFF);

    // PC wrap at the top of the address space.
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    run_cycle();
    redirect_valid = 1'b0;
    run_n(8);
    check_eq("wrap_req0", q_at(req_log, 0), 32'hFFFF_FFFC);
    check_eq("wrap_req1", q_at(req_log, 1), 32'h0000_0000);
    check_eq("wrap_req2", q_at(req_log, 2), 32'h0000_0004);
    check_eq("wrap_pc0", q_at(pc_log, 0), 32'hFFFF_FFFC);
    check_eq("wrap_dat0", q_at(dat_log, 0), 32'h0000_0003);
    check_eq("wrap_pc1", q_at(pc_log, 1), 32'h0000_0000);
    check_eq("wrap_dat1", q_at(dat_log, 1), 32'hFFFF_FFFF);

`ifdef INSTR_FETCH_ILLEGAL_CHECK_EN
    // Opcode legality flag on fixed instruction words.
    data_ovr_en = 1'b1;
    data_ovr    = 32'h0000_0013;
    do_reset(1);
    run_n(4);
    check_eq("ill_op_imm", q_at(ill_log, 0), 32'd0);
    data_ovr    = 32'h0000_0010;
    do_reset(1);
    run_n(4);
    check_eq("ill_low_bits", q_at(ill_log, 0), 32'd1);
    data_ovr    = 32'h0000_007F;
    do_reset(1);
    run_n(4);
    check_eq("ill_opcode", q_at(ill_log, 0), 32'd1);
    data_ovr_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
